// File: rtl/cmp_search_engine_pkg.sv
// Shared types for the comparator-driven binary search engine.
// State encodings and flag bit positions within {g, l, e}.
package cmp_search_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_EVAL
  } state_t;

  localparam int FLAG_G = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_E = 0;

  localparam logic [2:0] F_G = 3'b1 << FLAG_G;
  localparam logic [2:0] F_L = 3'b1 << FLAG_L;
  localparam logic [2:0] F_E = 3'b1 << FLAG_E;

endpackage

// File: rtl/cmp_search_engine_if.sv
// Control and comparator bundle between the search engine and its peers.
// The engine is the slave; the controller and comparator form the master side.
interface cmp_search_engine_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] guess;
  logic             cmp_g;
  logic             cmp_l;
  logic             cmp_e;

  modport master (
    output start,
    output cmp_g,
    output cmp_l,
    output cmp_e,
    input  busy,
    input  done,
    input  error,
    input  result,
    input  guess
  );

  modport slave (
    input  start,
    input  cmp_g,
    input  cmp_l,
    input  cmp_e,
    output busy,
    output done,
    output error,
    output result,
    output guess
  );

endinterface

// File: rtl/cmp_search_engine.sv
// Binary search over a comparator's hidden A operand.
// Each probe drives guess, waits LAT cycles, then narrows lo/hi.
module cmp_search_engine
  import cmp_search_engine_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int LAT   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  cmp_search_engine_if.slave     bus
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] guess;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;
  logic             error;
  logic [WIDTH-1:0] result;
  logic [2:0]       flags;

  // Extra sum bit keeps lo+hi from overflowing.
  function automatic logic [WIDTH-1:0] mid(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH:1];
  endfunction

  localparam state_t   PROBE_ST  = (LAT > 0) ? S_WAIT : S_EVAL;
  localparam logic [CW-1:0] PROBE_CNT =
    (LAT > 0) ? CW'(LAT - 1) : '0;

  assign flags = {bus.cmp_g, bus.cmp_l, bus.cmp_e};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      lo     <= '0;
      hi     <= MAX;
      guess  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            lo    <= '0;
            hi    <= MAX;
            guess <= mid('0, MAX);
            busy  <= 1'b1;
            cnt   <= PROBE_CNT;
            state <= PROBE_ST;
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_EVAL;
          else           cnt   <= cnt - 1'b1;
        end
        S_EVAL: begin
          unique case (1'b1)
            flags == F_E: begin
              result <= guess;
              error  <= 1'b0;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end
            flags == F_G && guess != hi: begin
              lo    <= guess + 1'b1;
              guess <= mid(guess + 1'b1, hi);
              cnt   <= PROBE_CNT;
              state <= PROBE_ST;
            end
            flags == F_L && guess != lo: begin
              hi    <= guess - 1'b1;
              guess <= mid(lo, guess - 1'b1);
              cnt   <= PROBE_CNT;
              state <= PROBE_ST;
            end
            // Bound hit or flags not one-hot.
            default: begin
              result <= guess;
              error  <= 1'b1;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_IDLE;
            end
          endcase
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.guess  = guess;
  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.error  = error;
  assign bus.result = result;

endmodule

// File: tb/tb_cmp_search_engine.sv
// Directed bench: two engines (LAT=0 and LAT=2) against behavioral comparators.
// Flags can be overridden to inject comparator faults.
module tb_cmp_search_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_search_engine_if #(.WIDTH(4)) if0 ();
  cmp_search_engine_if #(.WIDTH(4)) if2 ();

  cmp_search_engine #(.WIDTH(4), .LAT(0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  cmp_search_engine #(.WIDTH(4), .LAT(2)) u2 (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  logic       sel;
  logic       st;
  logic [3:0] a_val;
  logic       ovr_en;
  logic [2:0] ovr;

  int n_run = 0;
  int n_fail = 0;

  assign if0.start = sel ? 1'b0 : st;
  assign if2.start = sel ? st : 1'b0;

  assign if0.cmp_g = ovr_en ? ovr[2] : (a_val > if0.guess);
  assign if0.cmp_l = ovr_en ? ovr[1] : (a_val < if0.guess);
  assign if0.cmp_e = ovr_en ? ovr[0] : (a_val == if0.guess);
  assign if2.cmp_g = ovr_en ? ovr[2] : (a_val > if2.guess);
  assign if2.cmp_l = ovr_en ? ovr[1] : (a_val < if2.guess);
  assign if2.cmp_e = ovr_en ? ovr[0] : (a_val == if2.guess);

  logic       done_m;
  logic       busy_m;
  logic       err_m;
  logic [3:0] res_m;
  logic [3:0] guess_m;

  assign done_m  = sel ? if2.done   : if0.done;
  assign busy_m  = sel ? if2.busy   : if0.busy;
  assign err_m   = sel ? if2.error  : if0.error;
  assign res_m   = sel ? if2.result : if0.result;
  assign guess_m = sel ? if2.guess  : if0.guess;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run(
    input  logic        s,
    input  logic [3:0]  a,
    input  logic        oe,
    input  logic [2:0]  ov,
    input  logic        poke,
    output int          cyc,
    output logic [31:0] seq
  );
    logic [31:0] q;
    sel    = s;
    a_val  = a;
    ovr_en = oe;
    ovr    = ov;
    st     = 1'b1;
    @(negedge clk);
    st  = 1'b0;
    cyc = 0;
    q   = {28'h0, guess_m};
    chk("busy_rise", {31'h0, busy_m}, 32'h1);
    while (!done_m && cyc < 40) begin
      @(negedge clk);
      cyc++;
      st = poke && (cyc == 2);
      if (guess_m != q[3:0]) q = {q[27:0], guess_m};
    end
    st = 1'b0;
    chk("done_seen", {31'h0, done_m}, 32'h1);
    chk("busy_fall", {31'h0, busy_m}, 32'h0);
    seq = q;
  endtask

  int          cyc;
  logic [31:0] seq;
  int          seen;

  initial begin
    rst    = 1'b1;
    st     = 1'b0;
    sel    = 1'b0;
    a_val  = '0;
    ovr_en = 1'b0;
    ovr    = '0;
    repeat (2) @(negedge clk);
    chk("rst_guess0", {28'h0, if0.guess}, 32'h0);
    chk("rst_busy0",  {31'h0, if0.busy}, 32'h0);
    chk("rst_done2",  {31'h0, if2.done}, 32'h0);
    chk("rst_res2",   {28'h0, if2.result}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // One-probe hit
    run(1'b0, 4'd7, 1'b0, 3'b000, 1'b0, cyc, seq);
    chk("hit_cyc", cyc, 1);
    chk("hit_seq", seq, 32'h7);
    chk("hit_res", {28'h0, res_m}, 32'h7);
    chk("hit_err", {31'h0, err_m}, 32'h0);
    @(negedge clk);
    chk("hit_pulse", {31'h0, done_m}, 32'h0);

    // Upper extreme
    run(1'b0, 4'd15, 1'b0, 3'b000, 1'b0, cyc, seq);
    chk("up_cyc", cyc, 5);
    chk("up_seq", seq, 32'h0007BDEF);
    chk("up_res", {28'h0, res_m}, 32'hF);
    chk("up_err", {31'h0, err_m}, 32'h0);
    @(negedge clk);

    // Lower extreme, LAT=2
    run(1'b1, 4'd0, 1'b0, 3'b000, 1'b0, cyc, seq);
    chk("lo_cyc", cyc, 12);
    chk("lo_seq", seq, 32'h00007310);
    chk("lo_res", {28'h0, res_m}, 32'h0);
    chk("lo_err", {31'h0, err_m}, 32'h0);
    @(negedge clk);

    // Back-to-back sweep: each start lands in the previous done cycle
    for (int a = 0; a < 16; a++) begin
      run(1'b0, 4'(a), 1'b0, 3'b000, 1'b0, cyc, seq);
      chk("sw_res", {28'h0, res_m}, a);
      chk("sw_err", {31'h0, err_m}, 32'h0);
      chk("sw_k", {31'h0, cyc <= 5}, 32'h1);
    end
    @(negedge clk);

    // Faults: no flags, two flags, L at lower bound, G at upper bound
    run(1'b0, 4'd3, 1'b1, 3'b000, 1'b0, cyc, seq);
    chk("f000_cyc", cyc, 1);
    chk("f000_res", {28'h0, res_m}, 32'h7);
    chk("f000_err", {31'h0, err_m}, 32'h1);
    @(negedge clk);
    run(1'b0, 4'd3, 1'b1, 3'b011, 1'b0, cyc, seq);
    chk("f011_cyc", cyc, 1);
    chk("f011_res", {28'h0, res_m}, 32'h7);
    chk("f011_err", {31'h0, err_m}, 32'h1);
    @(negedge clk);
    run(1'b0, 4'd3, 1'b1, 3'b010, 1'b0, cyc, seq);
    chk("flo_cyc", cyc, 4);
    chk("flo_seq", seq, 32'h00007310);
    chk("flo_res", {28'h0, res_m}, 32'h0);
    chk("flo_err", {31'h0, err_m}, 32'h1);
    @(negedge clk);
    run(1'b0, 4'd3, 1'b1, 3'b100, 1'b1, cyc, seq);
    chk("fhi_cyc", cyc, 5);
    chk("fhi_res", {28'h0, res_m}, 32'hF);
    chk("fhi_err", {31'h0, err_m}, 32'h1);
    ovr_en = 1'b0;
    @(negedge clk);

    // Reset mid-search
    sel   = 1'b0;
    a_val = 4'd15;
    st    = 1'b1;
    @(negedge clk);
    st = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy",  {31'h0, if0.busy}, 32'h0);
    chk("mrst_guess", {28'h0, if0.guess}, 32'h0);
    chk("mrst_res",   {28'h0, if0.result}, 32'h0);
    chk("mrst_err",   {31'h0, if0.error}, 32'h0);
    chk("mrst_done",  {31'h0, if0.done}, 32'h0);
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (if0.done) seen++;
    end
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if0.done || if0.busy) seen++;
    end
    chk("mrst_idle", seen, 0);
    run(1'b0, 4'd9, 1'b0, 3'b000, 1'b0, cyc, seq);
    chk("mrst_again", {28'h0, res_m}, 32'h9);
    chk("mrst_seq", seq, 32'h0000007B9);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
